// File: rtl/pack_stream_to_blk_hls_deadlock_report_ctrl.sv
// Deadlock-report controller for the pack_stream_to_blk deadlock-monitor tree.
// Collects per-monitor block flags, filters transient blocks with a persistence
// counter, and presents one report record over valid/ready on a confirmed
// deadlock. A sticky deadlock flag is held until software clears it.
module pack_stream_to_blk_hls_deadlock_report_ctrl #(
  parameter int NUM_MON        = 4,
  parameter int PERSIST_CYCLES = 16,
  parameter int IDX_W          = $clog2(NUM_MON > 1 ? NUM_MON : 2),
  parameter int CNT_W          = $clog2(PERSIST_CYCLES + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               report_ready,
  output logic               report_valid,
  output logic [IDX_W-1:0]   report_idx,
  output logic [NUM_MON-1:0] report_mask,
  output logic [31:0]        report_time,
  output logic               deadlock
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    COUNT,
    REPORT,
    HALT
  } state_t;

  state_t             state, state_nx;
  logic [31:0]        stamp, stamp_nx;
  logic [31:0]        start, start_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               valid_nx;
  logic [IDX_W-1:0]   idx_nx;
  logic [NUM_MON-1:0] mask_nx;
  logic [31:0]        time_nx;
  logic               deadlock_nx;
  logic [IDX_W-1:0]   low_idx;
  logic               any_block;

  assign any_block = |mon_block;

  // Lowest-index set bit of mon_block; scanning downward lets the lowest win.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // before any conditional assignment, otherwise a latch is inferred.
    low_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (mon_block[i]) low_idx = IDX_W'(i);
    end
  end

  // Next-state and next-datapath values; clear dominates, enable-drop next.
  always_comb begin
    state_nx    = state;
    stamp_nx    = stamp;
    start_nx    = start;
    cnt_nx      = cnt;
    valid_nx    = report_valid;
    idx_nx      = report_idx;
    mask_nx     = report_mask;
    time_nx     = report_time;
    deadlock_nx = deadlock;

    if (clear) begin
      state_nx    = enable ? ARMED : IDLE;
      stamp_nx    = '0;
      start_nx    = '0;
      cnt_nx      = '0;
      valid_nx    = 1'b0;
      idx_nx      = '0;
      mask_nx     = '0;
      time_nx     = '0;
      deadlock_nx = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          stamp_nx = '0;
          cnt_nx   = '0;
          if (enable) state_nx = ARMED;
        end
        ARMED: begin
          if (!enable) begin
            state_nx = IDLE;
            stamp_nx = '0;
          end else begin
            stamp_nx = stamp + 32'd1;
            if (any_block) begin
              state_nx = COUNT;
              cnt_nx   = CNT_W'(1);
              // The stamp of the first blocked sample is the pre-increment value.
              start_nx = stamp;
            end
          end
        end
        COUNT: begin
          if (!enable) begin
            state_nx = IDLE;
            stamp_nx = '0;
            cnt_nx   = '0;
          end else begin
            stamp_nx = stamp + 32'd1;
            if (!any_block) begin
              // A single clear sample discards the window: glitch filtered.
              state_nx = ARMED;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
              if (cnt == CNT_W'(PERSIST_CYCLES - 1)) begin
                state_nx    = REPORT;
                valid_nx    = 1'b1;
                idx_nx      = low_idx;
                mask_nx     = mon_block;
                time_nx     = start;
                deadlock_nx = 1'b1;
              end
            end
          end
        end
        REPORT: begin
          // Record and stamp are frozen until the consumer takes it.
          if (report_ready) begin
            state_nx = HALT;
            valid_nx = 1'b0;
          end
        end
        HALT: begin
          // Only clear or reset leaves HALT.
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and datapath registers, asynchronously reset to the idle record.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      stamp        <= '0;
      start        <= '0;
      cnt          <= '0;
      report_valid <= 1'b0;
      report_idx   <= '0;
      report_mask  <= '0;
      report_time  <= '0;
      deadlock     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state        <= state_nx;
      stamp        <= stamp_nx;
      start        <= start_nx;
      cnt          <= cnt_nx;
      report_valid <= valid_nx;
      report_idx   <= idx_nx;
      report_mask  <= mask_nx;
      report_time  <= time_nx;
      deadlock     <= deadlock_nx;
    end
  end

endmodule

// File: tb/tb_pack_stream_to_blk_hls_deadlock_report_ctrl.sv
// Self-checking bench for the deadlock-report controller: directed scenarios
// plus randomized traffic compared against a behavioural model that tracks the
// arm-relative cycle count and the current run of blocked samples.
module tb_pack_stream_to_blk_hls_deadlock_report_ctrl;

  localparam int NM = 4;
  localparam int PC = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          clear;
  logic [NM-1:0] mon_block;
  logic          report_ready;
  logic          report_valid;
  logic [1:0]    report_idx;
  logic [NM-1:0] report_mask;
  logic [31:0]   report_time;
  logic          deadlock;

  pack_stream_to_blk_hls_deadlock_report_ctrl #(
    .NUM_MON(NM),
    .PERSIST_CYCLES(PC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .clear(clear),
    .mon_block(mon_block),
    .report_ready(report_ready),
    .report_valid(report_valid),
    .report_idx(report_idx),
    .report_mask(report_mask),
    .report_time(report_time),
    .deadlock(deadlock)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state.
  bit          m_valid, m_dl, m_armed, m_halt;
  logic [1:0]  m_idx;
  logic [3:0]  m_mask;
  logic [31:0] m_time, m_stamp, m_run_start;
  int          m_run_len;

  logic [39:0] got;
  assign got = {report_valid, deadlock, report_idx, report_mask, report_time};

  function automatic logic [39:0] exp_vec();
    return {m_valid, m_dl, m_idx, m_mask, m_time};
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_dl = 0; m_armed = 0; m_halt = 0;
    m_idx = '0; m_mask = '0; m_time = '0; m_stamp = '0;
    m_run_start = '0; m_run_len = 0;
  endtask

  // One clock edge of the reference: a report is raised once PC consecutive
  // nonzero samples have been seen while armed; its time is the first of them.
  task automatic model_step();
    if (clear) begin
      model_reset();
      m_armed = enable;
    end else if (m_halt) begin
      // frozen
    end else if (m_valid) begin
      if (report_ready) begin
        m_valid = 0;
        m_halt  = 1;
      end
    end else if (!m_armed) begin
      if (enable) begin
        m_armed = 1;
        m_stamp = '0;
      end
    end else if (!enable) begin
      m_armed   = 0;
      m_stamp   = '0;
      m_run_len = 0;
    end else begin
      if (mon_block != 0) begin
        if (m_run_len == 0) m_run_start = m_stamp;
        m_run_len++;
        if (m_run_len == PC) begin
          m_valid = 1; m_dl = 1;
          m_idx = lowest(mon_block); m_mask = mon_block; m_time = m_run_start;
        end
      end else begin
        m_run_len = 0;
      end
      m_stamp = m_stamp + 32'd1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; clear = 0; mon_block = '0; report_ready = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (got !== 40'd0) begin
      n_err++; $display("FAIL reset_hold got=%h exp=%h", got, 40'd0);
    end
    reset = 0;
    tick();
    n_cmp++;
    if (got !== exp_vec()) begin
      n_err++; $display("FAIL reset_idle got=%h exp=%h", got, exp_vec());
    end
  endtask

  task automatic test_basic_report();
    enable = 1; mon_block = '0; report_ready = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (got !== exp_vec()) begin
        n_err++; $display("FAIL basic_arm cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    mon_block = 4'b0110;
    for (int i = 0; i < PC; i++) begin
      tick();
      n_cmp++;
      if (got !== exp_vec()) begin
        n_err++; $display("FAIL basic_blk cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    n_cmp++;
    if (got !== {1'b1, 1'b1, 2'd1, 4'b0110, 32'd10}) begin
      n_err++; $display("FAIL basic_record got=%h exp=%h", got, {1'b1, 1'b1, 2'd1, 4'b0110, 32'd10});
    end
  endtask

  task automatic test_handshake();
    logic [39:0] snap;
    snap = got;
    mon_block = '0; report_ready = 0;
    for (int i = 0; i < 5; i++) begin
      mon_block = 4'($urandom);
      tick();
      n_cmp++;
      if (got !== snap || got !== exp_vec()) begin
        n_err++; $display("FAIL hs_stall cyc=%0d got=%h exp=%h", i, got, snap);
      end
    end
    report_ready = 1;
    tick();
    n_cmp++;
    if (report_valid !== 1'b0 || deadlock !== 1'b1 || got !== exp_vec()) begin
      n_err++; $display("FAIL hs_accept got=%h exp=%h", got, exp_vec());
    end
    report_ready = 0;
    for (int i = 0; i < 6; i++) begin
      mon_block = 4'($urandom);
      enable = i[0];
      tick();
      n_cmp++;
      if (deadlock !== 1'b1 || got !== exp_vec()) begin
        n_err++; $display("FAIL hs_halt cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    enable = 1;
  endtask

  task automatic test_clear();
    logic [3:0] last;
    clear = 1; enable = 1; mon_block = 4'hF;
    tick();
    clear = 0;
    n_cmp++;
    if (got !== 40'd0) begin
      n_err++; $display("FAIL clr_zero got=%h exp=%h", got, 40'd0);
    end
    mon_block = '0;
    repeat (3) tick();
    last = '0;
    for (int i = 0; i < PC; i++) begin
      last = 4'($urandom_range(1, 15));
      mon_block = last;
      tick();
    end
    n_cmp++;
    if (got !== {1'b1, 1'b1, lowest(last), last, 32'd3} || got !== exp_vec()) begin
      n_err++; $display("FAIL clr_rereport got=%h exp=%h", got, exp_vec());
    end
    // clear beats a simultaneous handshake
    clear = 1; report_ready = 1; mon_block = '0;
    tick();
    clear = 0; report_ready = 0;
    n_cmp++;
    if (got !== 40'd0) begin
      n_err++; $display("FAIL clr_vs_ready got=%h exp=%h", got, 40'd0);
    end
  endtask

  task automatic test_glitch();
    mon_block = 4'b1000;
    repeat (3) tick();
    mon_block = '0;
    tick();
    n_cmp++;
    if (report_valid !== 1'b0 || got !== exp_vec()) begin
      n_err++; $display("FAIL glitch_filtered got=%h exp=%h", got, exp_vec());
    end
    mon_block = 4'b1000;
    repeat (PC) tick();
    n_cmp++;
    if (got !== {1'b1, 1'b1, 2'd3, 4'b1000, 32'd4} || got !== exp_vec()) begin
      n_err++; $display("FAIL glitch_report got=%h exp=%h", got, exp_vec());
    end
  endtask

  task automatic test_enable_drop();
    clear = 1; enable = 1; mon_block = '0;
    tick();
    clear = 0;
    mon_block = 4'b0101;
    repeat (2) tick();
    enable = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      mon_block = 4'($urandom);
      tick();
      n_cmp++;
      if (report_valid !== 1'b0 || got !== exp_vec()) begin
        n_err++; $display("FAIL drop_idle cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    enable = 1; mon_block = '0;
    tick();
    repeat (2) tick();
    mon_block = 4'b0010;
    repeat (PC) tick();
    n_cmp++;
    if (got !== {1'b1, 1'b1, 2'd1, 4'b0010, 32'd2} || got !== exp_vec()) begin
      n_err++; $display("FAIL drop_rearm got=%h exp=%h", got, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1;
    model_reset();
    #1;
    n_cmp++;
    if (report_valid !== 1'b0 || deadlock !== 1'b0 || got !== 40'd0) begin
      n_err++; $display("FAIL areset_now got=%h exp=%h", got, 40'd0);
    end
    @(posedge clock);
    #1;
    reset = 0;
    enable = 1; mon_block = '0;
    tick();
    tick();
    mon_block = 4'b1100;
    repeat (PC) tick();
    n_cmp++;
    if (got !== {1'b1, 1'b1, 2'd2, 4'b1100, 32'd1} || got !== exp_vec()) begin
      n_err++; $display("FAIL areset_resume got=%h exp=%h", got, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable       = ($urandom_range(0, 19) != 0);
      clear        = ($urandom_range(0, 63) == 0);
      report_ready = ($urandom_range(0, 3) == 0);
      mon_block    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      tick();
      n_cmp++;
      if (got !== exp_vec()) begin
        n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    clear = 0;
  endtask

  initial begin
    test_reset();
    test_basic_report();
    test_handshake();
    test_clear();
    test_glitch();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pack_stream_to_blk_hls_deadlock_report_ctrl.md
# pack_stream_to_blk_hls_deadlock_report_ctrl

Deadlock-report controller for the pack_stream_to_blk deadlock-monitor tree. It collects the `block` flags of up to NUM_MON per-instance monitors and filters transient blocks with a persistence counter. On a confirmed deadlock it arbitrates a single offending monitor index and presents one report record over a valid/ready handshake, then holds a sticky `deadlock` flag until software clears it.

## Interface
Parameters:
- NUM_MON, 4, number of monitor `block` inputs (>=1)
- PERSIST_CYCLES, 16, consecutive blocked cycles required to confirm deadlock (>=2)
- IDX_W, $clog2(NUM_MON>1?NUM_MON:2), width of report_idx
- CNT_W, $clog2(PERSIST_CYCLES+1), width of persistence counter

Ports (one clock; `reset` asynchronous, active-high):
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous active-high reset
- enable  in  1  arm detection when high
- clear  in  1  synchronous clear of report and sticky flag
- mon_block  in  NUM_MON  per-monitor block flags, bit i from monitor i
- report_ready  in  1  consumer accepts report
- report_valid  out  1  report record valid
- report_idx  out  IDX_W  lowest-index blocked monitor at confirmation
- report_mask  out  NUM_MON  mon_block snapshot at confirmation
- report_time  out  32  arm-relative cycle stamp of first blocked sample
- deadlock  out  1  sticky deadlock indicator

## Operation
- States: IDLE, ARMED, COUNT, REPORT, HALT. Reset -> IDLE; all outputs 0; stamp, start, and persistence count 0.
- Priority per edge: clear > enable-drop > normal transitions.
- clear=1 (any state): go to ARMED if enable=1, else IDLE. Zero report_*, deadlock, stamp, and count.
- IDLE: stamp held at 0. enable=1 -> ARMED.
- ARMED: stamp += 1 per cycle, wrapping 2^32-1 -> 0. enable=0 -> IDLE. |mon_block -> COUNT with cnt=1; latch start=stamp (pre-increment value).
- COUNT: stamp keeps incrementing.
  - enable=0 -> IDLE.
  - mon_block==0 -> ARMED with cnt=0. Start is discarded; the glitch is filtered.
  - Otherwise cnt += 1. When cnt==PERSIST_CYCLES-1 and mon_block!=0 -> REPORT.
  - On that confirming edge, latch report_idx=lowest set bit of mon_block, report_mask=mon_block, report_time=start. Set deadlock=1.
  - The blocked set may change between samples; only "nonzero" must persist.
- REPORT: report_valid=1. report_idx, report_mask, and report_time are stable until the handshake. The stamp is frozen. enable is ignored. report_valid & report_ready -> HALT, report_valid=0.
- HALT: deadlock=1, report_* retain their values, the stamp is frozen, and enable and mon_block are ignored. Only clear or reset exits.
- Reset asserted in any state asynchronously forces IDLE and zeros all outputs, including mid-REPORT with no handshake.

## Timing
- enable rising, sampled at edge e: ARMED from e+1. First stamp increment at edge e+1.
- Detection latency: mon_block nonzero at edges k..k+PERSIST_CYCLES-1 gives report_valid=1 and deadlock=1 in the cycle after edge k+PERSIST_CYCLES-1. A single zero sample inside the window restarts counting.
- report_ready may be high before report_valid. Acceptance occurs on the first edge with both high, so the minimum REPORT residency is 1 cycle.
- The persistence window never exceeds PERSIST_CYCLES. The counter saturates because REPORT is entered at the terminal count.
- clear and report_ready in the same cycle: clear wins and no HALT is entered.
- All outputs are registered, with no combinational path from inputs.

## Test plan
- NUM_MON=4, PERSIST_CYCLES=4. Reset, then enable=1. Hold mon_block=4'b0110 for 4 cycles starting at stamp 10 -> report_valid=1 one cycle after the 4th sample, report_idx=1, report_mask=4'b0110, report_time=10, deadlock=1.
- Glitch filtering: mon_block=4'b1000 for 3 cycles, 0 for 1, then 4'b1000 for 4 -> no report after the first burst. Report after the second burst with report_time equal to the stamp of the second burst's first sample.
- Handshake: hold report_ready=0 for 5 cycles in REPORT -> outputs stable. Raise it -> report_valid drops next cycle, state HALT, deadlock stays 1 while mon_block toggles.
- clear in HALT with enable=1 -> all report_* and deadlock are 0 next cycle, stamp restarts from 0. A new 4-cycle block is reported again.
- enable dropped during COUNT (cnt=2) -> IDLE, no report. Re-enable and block 4 cycles -> report with report_time measured from the new arm.
- Asynchronous reset pulse mid-REPORT, between clock edges -> report_valid and deadlock go 0 immediately. After reset release with enable=1 -> normal ARMED operation.
